// File: rtl/key_pulse_conditioner.sv
// Key/switch input conditioner: 2-flop sync, per-key debounce, one-cycle press/release
// pulses and SW capture on LOAD_KEY press. Optional auto-repeat under KEY_AUTOREPEAT_EN.
module key_pulse_conditioner #(
    parameter int unsigned NUM_KEYS        = 3,
    parameter int unsigned SW_W            = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned LOAD_KEY        = 1,
    parameter int unsigned REPEAT_DELAY    = 50,
    parameter int unsigned REPEAT_PERIOD   = 10
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NUM_KEYS-1:0] KEY,
    input  logic [SW_W-1:0]     SW,
    output logic [NUM_KEYS-1:0] KEY_LEVEL,
    output logic [NUM_KEYS-1:0] KEY_PRESS,
    output logic [NUM_KEYS-1:0] KEY_RELEASE,
    output logic [SW_W-1:0]     SW_LATCHED,
    output logic                SW_VALID
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] HOLD_NEXT  = HOLD_W'(REPEAT_PERIOD - 1);
`else
    // Repeat timing has no consumer when auto-repeat is compiled out.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    logic [NUM_KEYS-1:0] key_s1;
    logic [NUM_KEYS-1:0] key_s2;
    logic [SW_W-1:0]     sw_s1;
    logic [SW_W-1:0]     sw_s2;
    logic [NUM_KEYS-1:0] press_next;
    logic                load_fire;
    logic [SW_W-1:0]     sw_latched_q;
    logic                sw_valid_q;

    // Two-flop synchronizers for every raw input bit
    always_ff @(posedge CLK) begin
        if (RESET) begin
            key_s1 <= '0;
            key_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic             stable_q;
        logic             stable_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             press_q;
        logic             press_d;
        logic             release_q;
        logic             release_d;
        logic             accept;

        assign accept = (key_s2[k] != stable_q) && (cnt_q == CNT_LAST);

`ifdef KEY_AUTOREPEAT_EN
        logic [HOLD_W-1:0] hold_q;
        logic [HOLD_W-1:0] hold_d;
        logic              rep_q;
        logic              rep_d;
`endif

        // Debounce counter, level update and event generation
        always_comb begin
            stable_d  = stable_q;
            cnt_d     = '0;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (key_s2[k] != stable_q) begin
                if (accept) begin
                    stable_d  = key_s2[k];
                    press_d   = key_s2[k];
                    release_d = stable_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef KEY_AUTOREPEAT_EN
            hold_d = '0;
            rep_d  = 1'b0;
            // A release accepted this cycle wins over a coincident repeat
            if (stable_q && !accept) begin
                if ((!rep_q && hold_q == HOLD_FIRST) || (rep_q && hold_q == HOLD_NEXT)) begin
                    press_d = 1'b1;
                    rep_d   = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                    rep_d  = rep_q;
                end
            end
`endif
        end

        always_ff @(posedge CLK) begin
            if (RESET) begin
                stable_q  <= 1'b0;
                cnt_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                stable_q  <= stable_d;
                cnt_q     <= cnt_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

`ifdef KEY_AUTOREPEAT_EN
        always_ff @(posedge CLK) begin
            if (RESET) begin
                hold_q <= '0;
                rep_q  <= 1'b0;
            end else begin
                hold_q <= hold_d;
                rep_q  <= rep_d;
            end
        end
`endif

        assign press_next[k]  = press_d;
        assign KEY_LEVEL[k]   = stable_q;
        assign KEY_PRESS[k]   = press_q;
        assign KEY_RELEASE[k] = release_q;
    end

    assign load_fire = press_next[LOAD_KEY];

    // Switch word captured alongside the LOAD_KEY press pulse
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sw_latched_q <= '0;
            sw_valid_q   <= 1'b0;
        end else begin
            sw_valid_q <= load_fire;
            if (load_fire) begin
                sw_latched_q <= sw_s2;
            end
        end
    end

    assign SW_LATCHED = sw_latched_q;
    assign SW_VALID   = sw_valid_q;

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Directed bench for key_pulse_conditioner: cycle-by-cycle vector table plus
// hand-written reset/hold sequences (auto-repeat expectations under KEY_AUTOREPEAT_EN).
module tb_key_pulse_conditioner;

    logic       CLK;
    logic       RESET;
    logic [2:0] KEY;
    logic [7:0] SW;
    logic [2:0] KEY_LEVEL;
    logic [2:0] KEY_PRESS;
    logic [2:0] KEY_RELEASE;
    logic [7:0] SW_LATCHED;
    logic       SW_VALID;

    int total = 0;
    int bad   = 0;

    key_pulse_conditioner dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .KEY        (KEY),
        .SW         (SW),
        .KEY_LEVEL  (KEY_LEVEL),
        .KEY_PRESS  (KEY_PRESS),
        .KEY_RELEASE(KEY_RELEASE),
        .SW_LATCHED (SW_LATCHED),
        .SW_VALID   (SW_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic [2:0] key;
        logic [7:0] sw;
        logic [2:0] lvl;
        logic [2:0] prs;
        logic [2:0] rel;
        logic [7:0] lat;
        logic       vld;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rst, logic [2:0] key, logic [7:0] sw, logic [2:0] lvl,
                                logic [2:0] prs, logic [2:0] rel, logic [7:0] lat, logic vld);
        vec_t v;
        v.rst = rst; v.key = key; v.sw = sw; v.lvl = lvl;
        v.prs = prs; v.rel = rel; v.lat = lat; v.vld = vld;
        vecs.push_back(v);
    endfunction

    // Clean level change held n cycles: accepted after edge 5 (6th cycle)
    function automatic void add_edge(logic [2:0] key, logic [7:0] sw, int n, logic [2:0] old_lvl,
                                     logic [7:0] old_lat, logic [7:0] new_lat, logic vld);
        for (int j = 0; j < n; j++) begin
            if (j < 5)
                add(1'b0, key, sw, old_lvl, 3'b000, 3'b000, old_lat, 1'b0);
            else if (j == 5)
                add(1'b0, key, sw, key, key & ~old_lvl, old_lvl & ~key, new_lat, vld);
            else
                add(1'b0, key, sw, key, 3'b000, 3'b000, new_lat, 1'b0);
        end
    endfunction

    function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int exp_t[$];
        int got_t[$];
        int nvalid;
        int nrel;
        int rel_at;
        int first_p;
        int np;

        RESET = 1'b1;
        KEY   = 3'b000;
        SW    = 8'h00;

        // Reset with switches set must keep everything at zero
        for (int i = 0; i < 10; i++) add(1'b1, 3'b000, 8'hFF, 3'b000, 3'b000, 3'b000, 8'h00, 1'b0);
        // Clean press/release of the load key
        add_edge(3'b010, 8'hA3, 10, 3'b000, 8'h00, 8'hA3, 1'b1);
        add_edge(3'b000, 8'hA3, 10, 3'b010, 8'hA3, 8'hA3, 1'b0);
        // Switch change with no press, then second load
        for (int i = 0; i < 4; i++) add(1'b0, 3'b000, 8'hD6, 3'b000, 3'b000, 3'b000, 8'hA3, 1'b0);
        add_edge(3'b010, 8'hD6, 8, 3'b000, 8'hA3, 8'hD6, 1'b1);
        add_edge(3'b000, 8'h55, 8, 3'b010, 8'hD6, 8'hD6, 1'b0);
        // 3-cycle glitch on key 0
        for (int i = 0; i < 3; i++) add(1'b0, 3'b001, 8'h55, 3'b000, 3'b000, 3'b000, 8'hD6, 1'b0);
        for (int i = 0; i < 8; i++) add(1'b0, 3'b000, 8'h55, 3'b000, 3'b000, 3'b000, 8'hD6, 1'b0);
        // 1-0-1-0 bounce
        add(1'b0, 3'b001, 8'h55, 3'b000, 3'b000, 3'b000, 8'hD6, 1'b0);
        add(1'b0, 3'b000, 8'h55, 3'b000, 3'b000, 3'b000, 8'hD6, 1'b0);
        add(1'b0, 3'b001, 8'h55, 3'b000, 3'b000, 3'b000, 8'hD6, 1'b0);
        for (int i = 0; i < 7; i++) add(1'b0, 3'b000, 8'h55, 3'b000, 3'b000, 3'b000, 8'hD6, 1'b0);
        // Minimal 6-cycle hold on key 0
        add_edge(3'b001, 8'h55, 6, 3'b000, 8'hD6, 8'hD6, 1'b0);
        add_edge(3'b000, 8'h55, 8, 3'b001, 8'hD6, 8'hD6, 1'b0);
        // Simultaneous keys 0 and 2, no SW capture
        add_edge(3'b101, 8'h55, 8, 3'b000, 8'hD6, 8'hD6, 1'b0);
        add_edge(3'b000, 8'h55, 8, 3'b101, 8'hD6, 8'hD6, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            RESET = vecs[i].rst;
            KEY   = vecs[i].key;
            SW    = vecs[i].sw;
            step();
            chk($sformatf("vec%0d", i),
                32'({KEY_LEVEL, KEY_PRESS, KEY_RELEASE, SW_LATCHED, SW_VALID}),
                32'({vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].lat, vecs[i].vld}));
        end

        // Long hold of the load key: single press, or repeats when enabled
`ifdef KEY_AUTOREPEAT_EN
        exp_t = '{6, 56, 66, 76, 86, 96};
`else
        exp_t = '{6};
`endif
        nvalid = 0;
        rel_at = 0;
        SW  = 8'h3C;
        KEY = 3'b010;
        for (int n = 1; n <= 120; n++) begin
            if (n == 101) KEY = 3'b000;
            step();
            if (KEY_PRESS[1]) got_t.push_back(n);
            if (SW_VALID) nvalid++;
            if (KEY_RELEASE[1] && rel_at == 0) rel_at = n;
        end
        chk("hold_npress", 32'(got_t.size()), 32'(exp_t.size()));
        for (int i = 0; i < exp_t.size(); i++)
            chk($sformatf("hold_press%0d_cycle", i), (i < got_t.size()) ? 32'(got_t[i]) : 32'hFFFF, 32'(exp_t[i]));
        chk("hold_nvalid", 32'(nvalid), 32'(exp_t.size()));
        chk("hold_release_cycle", 32'(rel_at), 32'd106);
        chk("hold_latched", 32'(SW_LATCHED), 32'h3C);

        // Key 2 held through reset: outputs zero, then one fresh press 6 cycles after reset falls
        RESET = 1'b1;
        KEY   = 3'b100;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("rst_hold%0d", i),
                32'({KEY_LEVEL, KEY_PRESS, KEY_RELEASE, SW_LATCHED, SW_VALID}), 32'h0);
        end
        RESET   = 1'b0;
        first_p = 0;
        np      = 0;
        nrel    = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (KEY_PRESS != 3'b000) begin
                np++;
                if (first_p == 0) first_p = n;
            end
            if (KEY_RELEASE != 3'b000) nrel++;
        end
        chk("post_rst_press_cycle", 32'(first_p), 32'd6);
        chk("post_rst_npress", 32'(np), 32'd1);
        chk("post_rst_nrelease", 32'(nrel), 32'd0);
        chk("post_rst_level", 32'(KEY_LEVEL), 32'b100);
        chk("post_rst_latched", 32'(SW_LATCHED), 32'h0);

        // Reset while key down, key gone afterwards: no release pulse
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) step();
        RESET = 1'b0;
        KEY   = 3'b000;
        np    = 0;
        nrel  = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (KEY_PRESS != 3'b000) np++;
            if (KEY_RELEASE != 3'b000) nrel++;
        end
        chk("rst_down_nrelease", 32'(nrel), 32'd0);
        chk("rst_down_npress", 32'(np), 32'd0);
        chk("rst_down_level", 32'(KEY_LEVEL), 32'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
